// File: rtl/env_pkg.sv
// Shared types and constants for the grid-world step engine: action codes,
// goal coordinates, FSM state encoding and the action-to-delta helper.
package env_pkg;

  localparam int unsigned ACTION_WIDTH    = 3;
  localparam int unsigned DEF_COORD_WIDTH = 8;

  localparam logic [DEF_COORD_WIDTH-1:0] COORD_MAX = {DEF_COORD_WIDTH{1'b1}};
  localparam logic [DEF_COORD_WIDTH-1:0] GOAL_X    = COORD_MAX;
  localparam logic [DEF_COORD_WIDTH-1:0] GOAL_Y    = COORD_MAX;

  // Names read as the axis moves: XM = x-1, XP = x+1, YM = y-1, YP = y+1
  typedef enum logic [ACTION_WIDTH-1:0] {
    ACT_XM    = 3'd0,
    ACT_XM_YM = 3'd1,
    ACT_YM    = 3'd2,
    ACT_XP_YM = 3'd3,
    ACT_XP    = 3'd4,
    ACT_XP_YP = 3'd5,
    ACT_YP    = 3'd6,
    ACT_XM_YP = 3'd7
  } action_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  typedef struct packed {
    logic x_inc;
    logic x_dec;
    logic y_inc;
    logic y_dec;
  } delta_t;

  function automatic delta_t action_delta(input action_e act);
    delta_t d;
    d = '0;
    case (act)
      ACT_XM:    d.x_dec = 1'b1;
      ACT_XM_YM: begin d.x_dec = 1'b1; d.y_dec = 1'b1; end
      ACT_YM:    d.y_dec = 1'b1;
      ACT_XP_YM: begin d.x_inc = 1'b1; d.y_dec = 1'b1; end
      ACT_XP:    d.x_inc = 1'b1;
      ACT_XP_YP: begin d.x_inc = 1'b1; d.y_inc = 1'b1; end
      ACT_YP:    d.y_inc = 1'b1;
      ACT_XM_YP: begin d.x_dec = 1'b1; d.y_inc = 1'b1; end
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/env_move.sv
// Combinational move: applies an action to (x, y); a move that would leave
// the grid on either axis leaves both coordinates unchanged.
module env_move
  import env_pkg::*;
#(
  parameter int unsigned COORD_WIDTH = DEF_COORD_WIDTH
) (
  input  logic [COORD_WIDTH-1:0] i_x,
  input  logic [COORD_WIDTH-1:0] i_y,
  input  action_e                i_action,
  output logic [COORD_WIDTH-1:0] o_next_x_c,
  output logic [COORD_WIDTH-1:0] o_next_y_c,
  output logic                   o_blocked_c
);

  localparam int unsigned EW = COORD_WIDTH + 1;

  delta_t          d;
  logic [EW-1:0]   sum_x;
  logic [EW-1:0]   sum_y;

  // One guard bit per axis: it is set exactly when 0-1 or MAX+1 occurred
  always_comb begin
    d     = action_delta(i_action);
    sum_x = {1'b0, i_x};
    sum_y = {1'b0, i_y};
    if (d.x_inc)      sum_x = sum_x + EW'(1);
    else if (d.x_dec) sum_x = sum_x - EW'(1);
    if (d.y_inc)      sum_y = sum_y + EW'(1);
    else if (d.y_dec) sum_y = sum_y - EW'(1);
    o_blocked_c = sum_x[EW-1] | sum_y[EW-1];
    o_next_x_c  = o_blocked_c ? i_x : sum_x[COORD_WIDTH-1:0];
    o_next_y_c  = o_blocked_c ? i_y : sum_y[COORD_WIDTH-1:0];
  end

endmodule

// File: rtl/env_step.sv
// Grid-world environment step: accepts (x, y, action), reads the reward table,
// returns next state, reward and goal flag. ENV_STEP_STATS_EN adds step/wall counters.
module env_step
  import env_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 19,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COORD_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [COORD_WIDTH-1:0] i_x,
  input  logic [COORD_WIDTH-1:0] i_y,
  input  logic [2:0]             i_action,
  output logic [ADDR_WIDTH-1:0]  o_r_addr,
  output logic                   o_r_read,
  input  logic [DATA_WIDTH-1:0]  i_r_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [COORD_WIDTH-1:0] o_next_x,
  output logic [COORD_WIDTH-1:0] o_next_y,
  output logic [DATA_WIDTH-1:0]  o_reward,
  output logic                   o_done
`ifdef ENV_STEP_STATS_EN
  ,
  output logic [31:0]            o_step_cnt,
  output logic [31:0]            o_wall_cnt
`endif
);

  localparam logic [COORD_WIDTH-1:0] CMAX = {COORD_WIDTH{1'b1}};

  state_e                 state_q,   state_d;
  logic [COORD_WIDTH-1:0] x_q,       x_d;
  logic [COORD_WIDTH-1:0] y_q,       y_d;
  action_e                act_q,     act_d;
  logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
  logic                   read_q,    read_d;
  logic                   valid_q,   valid_d;
  logic                   ready_q,   ready_d;
  logic [DATA_WIDTH-1:0]  reward_q,  reward_d;
  logic [COORD_WIDTH-1:0] nx_q,      nx_d;
  logic [COORD_WIDTH-1:0] ny_q,      ny_d;
  logic                   done_q,    done_d;
  logic                   blocked_q, blocked_d;

  logic [COORD_WIDTH-1:0] mv_x_c;
  logic [COORD_WIDTH-1:0] mv_y_c;
  logic                   mv_blocked_c;
  logic                   out_hs_c;

  env_move #(.COORD_WIDTH(COORD_WIDTH)) u_move (
    .i_x         (x_q),
    .i_y         (y_q),
    .i_action    (act_q),
    .o_next_x_c  (mv_x_c),
    .o_next_y_c  (mv_y_c),
    .o_blocked_c (mv_blocked_c)
  );

  assign out_hs_c = (state_q == S_OUT) && valid_q && i_ready;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    act_d     = act_q;
    addr_d    = addr_q;
    reward_d  = reward_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    done_d    = done_q;
    blocked_d = blocked_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          x_d     = i_x;
          y_d     = i_y;
          act_d   = action_e'(i_action);
          addr_d  = ADDR_WIDTH'({i_x, i_y, i_action});
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        reward_d  = i_r_data;
        nx_d      = mv_x_c;
        ny_d      = mv_y_c;
        done_d    = (mv_x_c == CMAX) && (mv_y_c == CMAX);
        blocked_d = mv_blocked_c;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (out_hs_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    read_d  = (state_d == S_READ);
    valid_d = (state_d == S_OUT);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      act_q     <= ACT_XM;
      addr_q    <= '0;
      read_q    <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      reward_q  <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      act_q     <= act_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      reward_q  <= reward_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      done_q    <= done_d;
      blocked_q <= blocked_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_r_addr = addr_q;
  assign o_r_read = read_q;
  assign o_valid  = valid_q;
  assign o_next_x = nx_q;
  assign o_next_y = ny_q;
  assign o_reward = reward_q;
  assign o_done   = done_q;

`ifdef ENV_STEP_STATS_EN
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] wall_cnt_q, wall_cnt_d;

  // Saturating counters, bumped only on an accepted result
  always_comb begin
    step_cnt_d = step_cnt_q;
    wall_cnt_d = wall_cnt_q;
    if (out_hs_c) begin
      if (step_cnt_q != '1) step_cnt_d = step_cnt_q + 32'd1;
      if (blocked_q && (wall_cnt_q != '1)) wall_cnt_d = wall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      step_cnt_q <= '0;
      wall_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      wall_cnt_q <= wall_cnt_d;
    end
  end

  assign o_step_cnt = step_cnt_q;
  assign o_wall_cnt = wall_cnt_q;
`endif

endmodule

// File: tb/tb_env_step.sv
// Bench for env_step: directed corner cases plus randomized steps against a
// behavioural grid model and a one-cycle-latency reward table.
module tb_env_step;

  localparam int CW   = 8;
  localparam int AW   = 19;
  localparam int DW   = 32;
  localparam int CMAX = 255;
  localparam int DX [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  localparam int DY [8] = '{0, -1, -1, -1, 0, 1, 1, 1};

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [CW-1:0] i_x;
  logic [CW-1:0] i_y;
  logic [2:0]    i_action;
  logic [AW-1:0] o_r_addr;
  logic          o_r_read;
  logic [DW-1:0] r_data;
  logic          o_valid;
  logic          i_ready;
  logic [CW-1:0] o_next_x;
  logic [CW-1:0] o_next_y;
  logic [DW-1:0] o_reward;
  logic          o_done;
`ifdef ENV_STEP_STATS_EN
  logic [31:0]   o_step_cnt;
  logic [31:0]   o_wall_cnt;
`endif

  env_step #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COORD_WIDTH(CW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_x      (i_x),
    .i_y      (i_y),
    .i_action (i_action),
    .o_r_addr (o_r_addr),
    .o_r_read (o_r_read),
    .i_r_data (r_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_next_x (o_next_x),
    .o_next_y (o_next_y),
    .o_reward (o_reward),
    .o_done   (o_done)
`ifdef ENV_STEP_STATS_EN
    ,
    .o_step_cnt (o_step_cnt),
    .o_wall_cnt (o_wall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reward table: data appears one cycle after a strobed read, noise otherwise
  logic [DW-1:0] tbl_val;
  always @(posedge clk) begin
    if (o_r_read) r_data <= tbl_val;
    else          r_data <= $urandom;
  end

  int n_pass  = 0;
  int n_total = 0;
  int m_steps = 0;
  int m_walls = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input int x, input int y, input int a,
                                output int nx, output int ny, output bit blk);
    int tx, ty;
    tx  = x + DX[a];
    ty  = y + DY[a];
    blk = (tx < 0) || (tx > CMAX) || (ty < 0) || (ty > CMAX);
    nx  = blk ? x : tx;
    ny  = blk ? y : ty;
  endfunction

  task automatic run_step(input int x, input int y, input int a, input logic [DW-1:0] rew,
                          input int hold, input bit keep_valid,
                          input int px, input int py, input int pa);
    int nx, ny, lat;
    bit blk, got;
    logic [AW-1:0] exp_addr;
    model(x, y, a, nx, ny, blk);
    exp_addr = AW'(x * 2048 + y * 8 + a);
    tbl_val  = rew;
    check("ready_before_req", o_ready, 1);
    i_valid  = 1'b1;
    i_x      = CW'(x);
    i_y      = CW'(y);
    i_action = 3'(a);
    i_ready  = (hold == 0);
    lat = 0;
    got = 0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        if (keep_valid) begin
          i_x = CW'(px); i_y = CW'(py); i_action = 3'(pa);
        end else begin
          i_valid = 1'b0;
        end
        check("read_strobe", o_r_read, 1);
        check("read_addr", o_r_addr, exp_addr);
        check("ready_busy", o_ready, 0);
      end
      if (lat == 2) check("read_once", o_r_read, 0);
      if (o_valid) got = 1;
    end
    check("latency", lat, 3);
    check("next_x", o_next_x, nx);
    check("next_y", o_next_y, ny);
    check("reward", o_reward, rew);
    check("done", o_done, (nx == CMAX) && (ny == CMAX));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", o_valid, 1);
      check("hold_next_x", o_next_x, nx);
      check("hold_reward", o_reward, rew);
      check("hold_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    m_steps++;
    if (blk) m_walls++;
    check("post_hs_valid", o_valid, 0);
    check("post_hs_ready", o_ready, 1);
    check("addr_held", o_r_addr, exp_addr);
`ifdef ENV_STEP_STATS_EN
    check("step_cnt", o_step_cnt, m_steps);
    check("wall_cnt", o_wall_cnt, m_walls);
`endif
  endtask

  function automatic int pick_coord();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 1;
      2:       return CMAX - 1;
      3:       return CMAX;
      default: return int'($urandom_range(0, CMAX));
    endcase
  endfunction

  initial begin
    bit any_valid;
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_x      = '0;
    i_y      = '0;
    i_action = '0;
    tbl_val  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_read", o_r_read, 0);
    check("rst_addr", o_r_addr, 0);
    check("rst_reward", o_reward, 0);
    check("rst_next", {o_next_x, o_next_y}, 0);
    check("rst_done", o_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_step(10, 20, 4, 32'h0000_0000, 0, 0, 0, 0, 0);
    run_step(0, 5, 7, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    run_step(254, 255, 4, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    run_step(255, 255, 5, 32'h1234_5678, 0, 0, 0, 0, 0);
    run_step(0, 0, 1, 32'h8000_0000, 0, 0, 0, 0, 0);
    // Stall in OUT with a second request pending; it must wait for IDLE
    run_step(100, 100, 2, 32'hCAFE_F00D, 5, 1, 37, 200, 6);
    run_step(37, 200, 6, 32'h0BAD_BEEF, 0, 0, 0, 0, 0);

    // Reset while the step sits in WAIT
    tbl_val  = 32'h5555_AAAA;
    i_valid  = 1'b1;
    i_x      = 8'd50;
    i_y      = 8'd60;
    i_action = 3'd3;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_steps = 0;
    m_walls = 0;
    check("abort_valid", o_valid, 0);
    check("abort_read", o_r_read, 0);
    check("abort_ready", o_ready, 1);
    check("abort_reward", o_reward, 0);
    check("abort_addr", o_r_addr, 0);
    any_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (o_valid) any_valid = 1;
    end
    check("abort_no_result", any_valid, 0);
`ifdef ENV_STEP_STATS_EN
    check("abort_step_cnt", o_step_cnt, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      int rx, ry, ra;
      rx = pick_coord();
      ry = pick_coord();
      ra = int'($urandom_range(0, 7));
      run_step(rx, ry, ra, DW'($urandom), int'($urandom_range(0, 2)), 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
